cilantro_ifetch: RTL and testbench
==================================

# cilantro_ifetch

Instruction fetch unit placed directly upstream of the cilantro RISC-V core. It generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel. In-order responses are buffered in a small prefetch FIFO, which presents one 32-bit instruction per cycle to the core's `instr_in` over a valid/ready handshake. A redirect input flushes all in-flight fetch state and restarts fetching at a new PC.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response data valid; responses arrive in order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  fetched instruction.
- `redirect_valid`  in  1  single-cycle pulse to restart fetching.
- `redirect_pc`  in  32  restart address.
- `instr_valid`  out  1  FIFO head is valid.
- `instr_ready`  in  1  core consumes the head.
- `instr_out`  out  32  head instruction; drives the core's `instr_in`.
- `instr_pc`  out  32  PC of the head instruction.
- `fetch_fault`  out  1  misaligned redirect seen; constant 0 unless the macro is defined.

## Operation
- **State:**
  - `fetch_pc`, 32 bits.
  - `outstanding` count, 0..FIFO_DEPTH.
  - `drop` count, 0..FIFO_DEPTH.
  - FIFO holding {instr, pc}, with `count`.
  - FSM with states RUN and FAULT.
- **Request issue:**
  - `imem_req_valid` = RUN && !redirect_valid && (`outstanding` + `count` < FIFO_DEPTH).
  - The credit rule guarantees every response has a FIFO slot; there is no backpressure on the response channel.
- **Request accept:** on `imem_req_valid && imem_req_ready`, `fetch_pc` += 4 (mod 2^32; wraps at 32'hFFFF_FFFC → 0) and `outstanding` += 1.
- **Responses:** each `imem_rsp_valid` decrements `outstanding`.
  - If `drop` > 0: data is discarded and `drop` -= 1.
  - Otherwise: {data, PC} is pushed to the FIFO. The PC comes from a per-request PC shadow queue, or from a `rsp_pc` register advanced by 4 per pushed response.
- **Pop:** on `instr_valid && instr_ready`.
- **Redirect cycle:**
  - FIFO is flushed.
  - `fetch_pc` and `rsp_pc` are set to `redirect_pc`.
  - `drop` = `outstanding` after this cycle's updates, i.e. all in-flight responses become stale. A response arriving in the redirect cycle itself is dropped and not counted into `drop`.
  - No request is issued in the redirect cycle.
- **Simultaneous events:**
  - Push and pop in the same cycle when full: allowed, `count` unchanged.
  - Pop and redirect in the same cycle: flush wins; the popped instruction is still considered consumed by the core.
  - Redirect during FAULT: see Configuration.
- **FSM:**
  - RUN → FAULT only via the macro feature.
  - FAULT → RUN only on `rst`.

## Timing
- **Reset values:**
  - `imem_req_valid` = 0, `instr_valid` = 0, `fetch_fault` = 0.
  - `imem_req_addr` = RESET_PC, `instr_out` = 0, `instr_pc` = 0.
  - `outstanding` = `drop` = `count` = 0, FSM = RUN.
- **Reset mid-operation:** all state is cleared. Responses to pre-reset requests are the memory's responsibility, since memory shares the same `rst`.
- **First request:** `imem_req_valid` = 1 in the first cycle after `rst` deasserts.
- **Latency:** a response in cycle N produces `instr_valid` at N+1. The FIFO is registered; there is no combinational rsp→instr path.
- **Throughput:** one instruction per cycle sustained with 1-cycle memory and `instr_ready` held at 1.
- **Redirect latency:** new request in cycle R+1; first new instruction visible no earlier than R+3 with 1-cycle memory.
- All outputs are driven from registers, except `imem_req_valid`, which is a combinational function of registered state and `redirect_valid`.

## Configuration
- **`CILANTRO_IFETCH_MISALIGN_CHECK_EN` defined:**
  - A redirect with `redirect_pc[1:0]` != 0 moves the FSM to FAULT and sets `fetch_fault` = 1 (sticky) in the next cycle.
  - FIFO is flushed and in-flight responses are dropped.
  - No further requests are issued; later redirects are ignored until `rst`.
- **Macro undefined:**
  - `redirect_pc[1:0]` is forced to 0 (target silently aligned).
  - FAULT is unreachable; `fetch_fault` is tied to 0.

## Test plan
- **Reset/sequential fetch:** `RESET_PC` = 32'h100, 1-cycle memory, `instr_ready` = 1 → request addresses 0x100, 0x104, 0x108…; `instr_pc` matches each; one instruction per cycle after the 2-cycle fill.
- **Backpressure:** `instr_ready` = 0 for 10 cycles → exactly FIFO_DEPTH (4) instructions buffered, `imem_req_valid` = 0, no lost or duplicated entry on release.
- **Redirect with in-flight requests:** 3-cycle memory, 3 outstanding, redirect to 0x2000 → 3 stale responses discarded; the next `instr_out`/`instr_pc` are the 0x2000 data.
- **Simultaneous pop and redirect with a full FIFO:** FIFO empty the next cycle; first request goes to `redirect_pc`.
- **Wrap:** redirect to 32'hFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- **Misaligned redirect to 0x1002:**
  - Macro on: `fetch_fault` = 1, no further requests until `rst`.
  - Macro off: fetch proceeds from 0x1000.

Source files
------------

// File: rtl/cilantro_ifetch.sv
// cilantro_ifetch: sequential instruction fetch with credit-limited prefetch FIFO and redirect flush.
// Optional misaligned-redirect fault is enabled by defining CILANTRO_IFETCH_MISALIGN_CHECK_EN.
module cilantro_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {RUN, FAULT} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic             valid_q;
    logic             fault_q;

    logic             redirect_en;
    logic             misaligned;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic [31:0]      redirect_tgt;
    logic [SUM_W-1:0] credit_used;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] count_next;

    // Credit rule: in-flight requests plus buffered entries never exceed the FIFO size.
    always_comb begin
        redirect_en  = redirect_valid && (state == RUN);
        redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`ifdef CILANTRO_IFETCH_MISALIGN_CHECK_EN
        misaligned   = (redirect_pc[1:0] != 2'b00);
`else
        misaligned   = 1'b0;
`endif
        credit_used      = SUM_W'(outstanding) + SUM_W'(count);
        imem_req_valid   = !rst && (state == RUN) && !redirect_valid
                           && (credit_used < SUM_W'(FIFO_DEPTH));
        req_fire         = imem_req_valid && imem_req_ready;
        push             = imem_rsp_valid && (drop == '0) && !redirect_en;
        pop              = valid_q && instr_ready;
        outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        count_next       = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[PTR_W'(i)] <= '0;
                fifo_pc[PTR_W'(i)]    <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            if (redirect_en) begin
                // Everything still in flight becomes stale; the FIFO restarts empty.
                fetch_pc <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                drop     <= outstanding_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                valid_q  <= 1'b0;
                if (misaligned) begin
                    state   <= FAULT;
                    fault_q <= 1'b1;
                end
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rsp_data;
                    fifo_pc[wr_ptr]    <= rsp_pc;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                    rsp_pc             <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count   <= count_next;
                valid_q <= (count_next != '0);
            end
        end
    end

    assign imem_req_addr = fetch_pc;
    assign instr_valid   = valid_q;
    assign instr_out     = fifo_instr[rd_ptr];
    assign instr_pc      = fifo_pc[rd_ptr];
    assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_cilantro_ifetch.sv
// Directed bench for cilantro_ifetch with an in-order fixed-latency memory model.
module tb_cilantro_ifetch;
    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int n_checks;
    int n_errors;
    int cyc;
    int lat;
    int n_acc;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] pop_pc   [$];
    logic [31:0] pop_data [$];

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_instr_valid;
    logic [31:0] s_instr_out;
    logic [31:0] s_instr_pc;
    logic        s_fault;

    cilantro_ifetch #(
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock cycle: memory drives its response, outputs are sampled mid-cycle, then the edge.
    task automatic step();
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr[0] ^ 32'hDEAD_0000;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr_out   = instr_out;
        s_instr_pc    = instr_pc;
        s_fault       = fetch_fault;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            n_acc++;
        end
        if (instr_valid && instr_ready) begin
            pop_pc.push_back(instr_pc);
            pop_data.push_back(instr_out);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        mq_addr.delete();
        mq_due.delete();
        step();
        step();
        rst = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        pop_pc.delete();
        pop_data.delete();
        n_acc = 0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        lat            = 1;
        step();
        step();
        n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b expected 0", s_req_valid); end
        n_checks++; if (s_instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_instr_valid: got %b expected 0", s_instr_valid); end
        n_checks++; if (s_fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b expected 0", s_fault); end
        n_checks++; if (s_req_addr !== 32'h0000_0100) begin n_errors++; $display("FAIL reset_req_addr: got %h expected 00000100", s_req_addr); end
        n_checks++; if (s_instr_out !== 32'h0) begin n_errors++; $display("FAIL reset_instr_out: got %h expected 00000000", s_instr_out); end
        n_checks++; if (s_instr_pc !== 32'h0) begin n_errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", s_instr_pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        do_reset();
        lat         = 1;
        instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            exp_addr = 32'h100 + 32'(4 * k);
            n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== exp_addr) begin n_errors++; $display("FAIL seq_req c%0d: got %b/%h expected 1/%h", k, s_req_valid, s_req_addr, exp_addr); end
            n_checks++; if (s_instr_valid !== (k >= 2)) begin n_errors++; $display("FAIL seq_instr_valid c%0d: got %b expected %b", k, s_instr_valid, (k >= 2)); end
            if (k >= 2) begin
                exp_pc = 32'h100 + 32'(4 * (k - 2));
                n_checks++; if (s_instr_pc !== exp_pc || s_instr_out !== (exp_pc ^ 32'hDEAD_0000)) begin n_errors++; $display("FAIL seq_instr c%0d: got %h/%h expected %h/%h", k, s_instr_pc, s_instr_out, exp_pc, exp_pc ^ 32'hDEAD_0000); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        lat         = 1;
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) step();
        n_checks++; if (n_acc !== 4) begin n_errors++; $display("FAIL bp_accepted: got %0d expected 4", n_acc); end
        n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_req_valid: got %b expected 0", s_req_valid); end
        n_checks++; if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h100) begin n_errors++; $display("FAIL bp_head: got %b/%h expected 1/00000100", s_instr_valid, s_instr_pc); end
        instr_ready = 1'b1;
        for (int k = 0; k < 30 && pop_pc.size() < 8; k++) step();
        n_checks++; if (pop_pc.size() < 8) begin n_errors++; $display("FAIL bp_release_count: got %0d expected 8", pop_pc.size()); end
        for (int i = 0; i < 8 && i < pop_pc.size(); i++) begin
            exp_pc = 32'h100 + 32'(4 * i);
            n_checks++; if (pop_pc[i] !== exp_pc || pop_data[i] !== (exp_pc ^ 32'hDEAD_0000)) begin n_errors++; $display("FAIL bp_release_pop%0d: got %h/%h expected %h/%h", i, pop_pc[i], pop_data[i], exp_pc, exp_pc ^ 32'hDEAD_0000); end
        end
    endtask

    task automatic test_redirect();
        logic stale_seen;
        do_reset();
        lat         = 3;
        instr_ready = 1'b1;
        step();
        step();
        step();
        n_checks++; if (n_acc !== 3) begin n_errors++; $display("FAIL redir_inflight: got %0d expected 3", n_acc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL redir_cycle_req: got %b expected 0", s_req_valid); end
        step();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h2000) begin n_errors++; $display("FAIL redir_first_req: got %b/%h expected 1/00002000", s_req_valid, s_req_addr); end
        stale_seen = s_instr_valid;
        for (int k = 0; k < 3; k++) begin
            step();
            stale_seen = stale_seen | s_instr_valid;
        end
        n_checks++; if (stale_seen !== 1'b0) begin n_errors++; $display("FAIL redir_stale: got %b expected 0", stale_seen); end
        step();
        n_checks++; if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h2000 || s_instr_out !== 32'hDEAD_2000) begin n_errors++; $display("FAIL redir_new_head: got %b/%h/%h expected 1/00002000/dead2000", s_instr_valid, s_instr_pc, s_instr_out); end
        n_checks++; if (pop_pc.size() !== 1) begin n_errors++; $display("FAIL redir_pops: got %0d expected 1", pop_pc.size()); end
    endtask

    task automatic test_pop_redirect_full();
        do_reset();
        lat         = 1;
        instr_ready = 1'b0;
        for (int k = 0; k < 8; k++) step();
        n_checks++; if (s_instr_valid !== 1'b1 || s_req_valid !== 1'b0) begin n_errors++; $display("FAIL pr_full: got %b/%b expected 1/0", s_instr_valid, s_req_valid); end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (pop_pc.size() !== 1 || s_instr_pc !== 32'h100) begin n_errors++; $display("FAIL pr_pop: got %0d/%h expected 1/00000100", pop_pc.size(), s_instr_pc); end
        step();
        n_checks++; if (s_instr_valid !== 1'b0) begin n_errors++; $display("FAIL pr_flushed: got %b expected 0", s_instr_valid); end
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h3000) begin n_errors++; $display("FAIL pr_req: got %b/%h expected 1/00003000", s_req_valid, s_req_addr); end
        step();
        step();
        n_checks++; if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h3000 || s_instr_out !== 32'hDEAD_3000) begin n_errors++; $display("FAIL pr_head: got %b/%h/%h expected 1/00003000/dead3000", s_instr_valid, s_instr_pc, s_instr_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        lat            = 1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFF8) begin n_errors++; $display("FAIL wrap_req0: got %b/%h expected 1/fffffff8", s_req_valid, s_req_addr); end
        step();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_req1: got %b/%h expected 1/fffffffc", s_req_valid, s_req_addr); end
        step();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_req2: got %b/%h expected 1/00000000", s_req_valid, s_req_addr); end
        n_checks++; if (s_instr_pc !== 32'hFFFF_FFF8 || s_instr_out !== 32'h2152_FFF8) begin n_errors++; $display("FAIL wrap_instr0: got %h/%h expected fffffff8/2152fff8", s_instr_pc, s_instr_out); end
        step();
        n_checks++; if (s_instr_pc !== 32'hFFFF_FFFC || s_instr_out !== 32'h2152_FFFC) begin n_errors++; $display("FAIL wrap_instr1: got %h/%h expected fffffffc/2152fffc", s_instr_pc, s_instr_out); end
        step();
        n_checks++; if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h0 || s_instr_out !== 32'hDEAD_0000) begin n_errors++; $display("FAIL wrap_instr2: got %b/%h/%h expected 1/00000000/dead0000", s_instr_valid, s_instr_pc, s_instr_out); end
    endtask

    task automatic test_misalign();
        do_reset();
        lat            = 1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        step();
        redirect_valid = 1'b0;
`ifdef CILANTRO_IFETCH_MISALIGN_CHECK_EN
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if (s_fault !== 1'b1 || s_req_valid !== 1'b0) begin n_errors++; $display("FAIL mis_fault c%0d: got %b/%b expected 1/0", k, s_fault, s_req_valid); end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++; if (s_fault !== 1'b1 || s_req_valid !== 1'b0) begin n_errors++; $display("FAIL mis_ignore_redirect: got %b/%b expected 1/0", s_fault, s_req_valid); end
        do_reset();
        step();
        n_checks++; if (s_fault !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin n_errors++; $display("FAIL mis_reset_recover: got %b/%b/%h expected 0/1/00000100", s_fault, s_req_valid, s_req_addr); end
`else
        step();
        n_checks++; if (s_fault !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h1000) begin n_errors++; $display("FAIL mis_aligned_req0: got %b/%b/%h expected 0/1/00001000", s_fault, s_req_valid, s_req_addr); end
        step();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h1004) begin n_errors++; $display("FAIL mis_aligned_req1: got %b/%h expected 1/00001004", s_req_valid, s_req_addr); end
        step();
        n_checks++; if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h1000 || s_instr_out !== 32'hDEAD_1000) begin n_errors++; $display("FAIL mis_aligned_instr: got %b/%h/%h expected 1/00001000/dead1000", s_instr_valid, s_instr_pc, s_instr_out); end
`endif
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        lat            = 1;
        n_acc          = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_pop_redirect_full();
        test_wrap();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
